// File: rtl/conv_transposed_3d_grouped_tap_engine.sv
// conv_transposed_3d_grouped_tap_engine: scatter tap generator for a grouped, strided, padded 3D transposed convolution
module conv_transposed_3d_grouped_tap_engine #(
   parameter int DATA_W = 16,
   parameter int ACC_W  = 32,
   parameter int K      = 3,
   parameter int STRIDE = 2,
   parameter int PAD    = 1,
   parameter int IN_CH  = 4,
   parameter int OUT_CH = 4,
   parameter int GROUPS = 2,
   parameter int OUT_D  = 8,
   parameter int OUT_H  = 8,
   parameter int OUT_W  = 8,
   parameter int CW     = 8,
   parameter int AW     = 12
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic [7:0]        in_ch,
   input  logic [CW-1:0]     in_d,
   input  logic [CW-1:0]     in_h,
   input  logic [CW-1:0]     in_w,
   output logic              w_rd_en,
   output logic [AW-1:0]     w_addr,
   input  logic [DATA_W-1:0] w_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [ACC_W-1:0]  out_data,
   output logic              out_keep,
   output logic [7:0]        out_ch,
   output logic [CW:0]       out_d,
   output logic [CW:0]       out_h,
   output logic [CW:0]       out_w,
   output logic              out_last,
   output logic              err_ch
);
   localparam int ICG = IN_CH / GROUPS;
   localparam int OCG = OUT_CH / GROUPS;
   localparam int OB  = (OCG > 1) ? $clog2(OCG) : 1;
   localparam int KB  = (K > 1) ? $clog2(K) : 1;
   localparam int XW  = CW + 8;

   typedef enum logic {IDLE, RUN} state_t;

   // Raw output coordinate of a tap; wide enough that the sign is never lost.
   function automatic logic signed [XW-1:0] tap_coord(input logic [CW-1:0] x, input logic [KB-1:0] k);
      return $signed(XW'(x)) * $signed(XW'(STRIDE)) - $signed(XW'(PAD)) + $signed(XW'(k));
   endfunction

   function automatic logic in_range(input logic signed [XW-1:0] c, input int lim);
      return !c[XW-1] && (c < $signed(XW'(lim)));
   endfunction

   state_t              state_q, state_d;
   logic                rdy_q;
   logic                err_q, err_d;
   logic [DATA_W-1:0]   data_q, data_d;
   logic [7:0]          ch_q, ch_d, g_q, g_d;
   logic [CW-1:0]       d_q, d_d, h_q, h_d, w_q, w_d;
   logic [OB-1:0]       ocl_q, ocl_d;
   logic [KB-1:0]       kd_q, kd_d, kh_q, kh_d, kw_q, kw_d;
   logic                p1_v_q, p1_v_d, p1_keep_q, p1_keep_d, p1_last_q, p1_last_d;
   logic [DATA_W-1:0]   p1_data_q, p1_data_d;
   logic [7:0]          p1_ch_q, p1_ch_d;
   logic [CW:0]         p1_d_q, p1_d_d, p1_h_q, p1_h_d, p1_w_q, p1_w_d;
   logic                o_v_q, o_v_d, o_keep_q, o_keep_d, o_last_q, o_last_d;
   logic [ACC_W-1:0]    o_data_q, o_data_d;
   logic [7:0]          o_ch_q, o_ch_d;
   logic [CW:0]         o_d_q, o_d_d, o_h_q, o_h_d, o_w_q, o_w_d;

   logic                adv, issue, accept, ch_ok, keep_c, last_tap;
   logic                kw_wrap, kh_wrap, kd_wrap, ocl_wrap;
   logic signed [XW-1:0] od_c, oh_c, ow_c;
   logic [7:0]          oc_c;
   logic [AW-1:0]       addr_c;
   logic signed [2*DATA_W-1:0] a_x, b_x, prod_x;

   assign adv      = !o_v_q || out_ready;
   assign issue    = (state_q == RUN) && adv;
   assign in_ready = rdy_q && (state_q == IDLE);
   assign accept   = in_valid && in_ready;
   assign ch_ok    = in_ch < 8'(IN_CH);

   assign kw_wrap  = kw_q == KB'(K - 1);
   assign kh_wrap  = kh_q == KB'(K - 1);
   assign kd_wrap  = kd_q == KB'(K - 1);
   assign ocl_wrap = ocl_q == OB'(OCG - 1);
   assign last_tap = ocl_wrap && kd_wrap && kh_wrap && kw_wrap;

   assign od_c   = tap_coord(d_q, kd_q);
   assign oh_c   = tap_coord(h_q, kh_q);
   assign ow_c   = tap_coord(w_q, kw_q);
   assign keep_c = in_range(od_c, OUT_D) && in_range(oh_c, OUT_H) && in_range(ow_c, OUT_W);
   assign oc_c   = g_q * 8'(OCG) + 8'(ocl_q);
   assign addr_c = (((AW'(ch_q) * AW'(OCG) + AW'(ocl_q)) * AW'(K) + AW'(kd_q)) * AW'(K)
                   + AW'(kh_q)) * AW'(K) + AW'(kw_q);

   // Cropped taps never touch the weight RAM.
   assign w_rd_en = issue && keep_c;
   assign w_addr  = w_rd_en ? addr_c : '0;

   assign a_x    = (2*DATA_W)'($signed(p1_data_q));
   assign b_x    = (2*DATA_W)'($signed(w_data));
   assign prod_x = a_x * b_x;

   assign out_valid = o_v_q;
   assign out_data  = o_data_q;
   assign out_keep  = o_keep_q;
   assign out_ch    = o_ch_q;
   assign out_d     = o_d_q;
   assign out_h     = o_h_q;
   assign out_w     = o_w_q;
   assign out_last  = o_last_q;
   assign err_ch    = err_q;

   // Next state: voxel capture, tap counter walk, and both pipeline stages gated by adv.
   always_comb begin
      state_d   = state_q;
      err_d     = accept && !ch_ok;
      data_d    = data_q;
      ch_d      = ch_q;
      g_d       = g_q;
      d_d       = d_q;
      h_d       = h_q;
      w_d       = w_q;
      ocl_d     = ocl_q;
      kd_d      = kd_q;
      kh_d      = kh_q;
      kw_d      = kw_q;
      p1_v_d    = p1_v_q;
      p1_keep_d = p1_keep_q;
      p1_last_d = p1_last_q;
      p1_data_d = p1_data_q;
      p1_ch_d   = p1_ch_q;
      p1_d_d    = p1_d_q;
      p1_h_d    = p1_h_q;
      p1_w_d    = p1_w_q;
      o_v_d     = o_v_q;
      o_keep_d  = o_keep_q;
      o_last_d  = o_last_q;
      o_data_d  = o_data_q;
      o_ch_d    = o_ch_q;
      o_d_d     = o_d_q;
      o_h_d     = o_h_q;
      o_w_d     = o_w_q;
      if (accept && ch_ok) begin
         state_d = RUN;
         data_d  = in_data;
         ch_d    = in_ch;
         g_d     = in_ch / 8'(ICG);
         d_d     = in_d;
         h_d     = in_h;
         w_d     = in_w;
         ocl_d   = '0;
         kd_d    = '0;
         kh_d    = '0;
         kw_d    = '0;
      end
      if (issue) begin
         kw_d  = kw_wrap ? '0 : kw_q + KB'(1);
         kh_d  = !kw_wrap ? kh_q : (kh_wrap ? '0 : kh_q + KB'(1));
         kd_d  = !(kw_wrap && kh_wrap) ? kd_q : (kd_wrap ? '0 : kd_q + KB'(1));
         ocl_d = !(kw_wrap && kh_wrap && kd_wrap) ? ocl_q : (ocl_wrap ? '0 : ocl_q + OB'(1));
         state_d = last_tap ? IDLE : RUN;
      end
      if (adv) begin
         p1_v_d    = issue;
         p1_keep_d = keep_c;
         p1_last_d = last_tap;
         p1_data_d = data_q;
         p1_ch_d   = oc_c;
         p1_d_d    = od_c[CW:0];
         p1_h_d    = oh_c[CW:0];
         p1_w_d    = ow_c[CW:0];
         o_v_d     = p1_v_q;
         o_keep_d  = p1_keep_q;
         o_last_d  = p1_last_q;
         o_data_d  = p1_keep_q ? ACC_W'(prod_x) : '0;
         o_ch_d    = p1_ch_q;
         o_d_d     = p1_d_q;
         o_h_d     = p1_h_q;
         o_w_d     = p1_w_q;
      end
   end

   // State register; reset empties both stages and holds in_ready low until the first clock after release.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         rdy_q     <= 1'b0;
         err_q     <= 1'b0;
         data_q    <= '0;
         ch_q      <= '0;
         g_q       <= '0;
         d_q       <= '0;
         h_q       <= '0;
         w_q       <= '0;
         ocl_q     <= '0;
         kd_q      <= '0;
         kh_q      <= '0;
         kw_q      <= '0;
         p1_v_q    <= 1'b0;
         p1_keep_q <= 1'b0;
         p1_last_q <= 1'b0;
         p1_data_q <= '0;
         p1_ch_q   <= '0;
         p1_d_q    <= '0;
         p1_h_q    <= '0;
         p1_w_q    <= '0;
         o_v_q     <= 1'b0;
         o_keep_q  <= 1'b0;
         o_last_q  <= 1'b0;
         o_data_q  <= '0;
         o_ch_q    <= '0;
         o_d_q     <= '0;
         o_h_q     <= '0;
         o_w_q     <= '0;
      end else begin
         state_q   <= state_d;
         rdy_q     <= 1'b1;
         err_q     <= err_d;
         data_q    <= data_d;
         ch_q      <= ch_d;
         g_q       <= g_d;
         d_q       <= d_d;
         h_q       <= h_d;
         w_q       <= w_d;
         ocl_q     <= ocl_d;
         kd_q      <= kd_d;
         kh_q      <= kh_d;
         kw_q      <= kw_d;
         p1_v_q    <= p1_v_d;
         p1_keep_q <= p1_keep_d;
         p1_last_q <= p1_last_d;
         p1_data_q <= p1_data_d;
         p1_ch_q   <= p1_ch_d;
         p1_d_q    <= p1_d_d;
         p1_h_q    <= p1_h_d;
         p1_w_q    <= p1_w_d;
         o_v_q     <= o_v_d;
         o_keep_q  <= o_keep_d;
         o_last_q  <= o_last_d;
         o_data_q  <= o_data_d;
         o_ch_q    <= o_ch_d;
         o_d_q     <= o_d_d;
         o_h_q     <= o_h_d;
         o_w_q     <= o_w_d;
      end
   end
endmodule

// File: tb/tb_conv_transposed_3d_grouped_tap_engine.sv
// tb_conv_transposed_3d_grouped_tap_engine: randomized bench against a loop-nest model of the tap scatter
module tb_conv_transposed_3d_grouped_tap_engine;
   localparam int K = 3, STRIDE = 2, PAD = 1, IN_CH = 4, OUT_CH = 4, GROUPS = 2, OUT_N = 8;
   localparam int ICG = IN_CH / GROUPS, OCG = OUT_CH / GROUPS, NT = OCG * K * K * K;

   typedef struct packed {
      logic [31:0] data;
      logic        keep;
      logic [7:0]  ch;
      logic [8:0]  d, h, w;
      logic        last;
   } prod_t;

   logic        clk, rst_n, in_valid, in_ready, w_rd_en, out_valid, out_ready;
   logic        out_keep, out_last, err_ch;
   logic [15:0] in_data, w_data;
   logic [7:0]  in_ch, in_d, in_h, in_w, out_ch;
   logic [11:0] w_addr;
   logic [31:0] out_data;
   logic [8:0]  out_d, out_h, out_w;
   logic [15:0] mem [0:4095];

   prod_t got[$];
   prod_t exp_q[$];
   int    n_cmp = 0, n_err = 0, rd_cnt = 0, stall_rd = 0;
   bit    done;

   conv_transposed_3d_grouped_tap_engine dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .in_ch(in_ch), .in_d(in_d), .in_h(in_h), .in_w(in_w), .w_rd_en(w_rd_en), .w_addr(w_addr),
      .w_data(w_data), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_keep(out_keep), .out_ch(out_ch), .out_d(out_d), .out_h(out_h), .out_w(out_w),
      .out_last(out_last), .err_ch(err_ch)
   );

   initial clk = 0;
   always #5 clk = ~clk;

   always @(posedge clk) if (w_rd_en) w_data <= mem[w_addr];

   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) got.push_back({out_data, out_keep, out_ch, out_d, out_h, out_w, out_last});
      if (rst_n && w_rd_en) rd_cnt++;
      if (rst_n && w_rd_en && out_valid && !out_ready) stall_rd++;
   end

   // Expected product stream of one voxel, straight from the transposed-convolution scatter rule.
   function automatic void model(input int x, input int ch, input int d, input int h, input int w);
      prod_t p;
      int od, oh, ow, a, wt;
      for (int o = 0; o < OCG; o++)
         for (int kd = 0; kd < K; kd++)
            for (int kh = 0; kh < K; kh++)
               for (int kw = 0; kw < K; kw++) begin
                  od = d * STRIDE - PAD + kd;
                  oh = h * STRIDE - PAD + kh;
                  ow = w * STRIDE - PAD + kw;
                  a  = (((ch * OCG + o) * K + kd) * K + kh) * K + kw;
                  wt = $signed(mem[a]);
                  p.keep = od >= 0 && od < OUT_N && oh >= 0 && oh < OUT_N && ow >= 0 && ow < OUT_N;
                  p.data = p.keep ? 32'(x * wt) : 32'd0;
                  p.ch   = 8'((ch / ICG) * OCG + o);
                  p.d    = 9'(od);
                  p.h    = 9'(oh);
                  p.w    = 9'(ow);
                  p.last = o == OCG - 1 && kd == K - 1 && kh == K - 1 && kw == K - 1;
                  exp_q.push_back(p);
               end
   endfunction

   task automatic send(input int x, input int ch, input int d, input int h, input int w);
      int t = 0;
      while (!in_ready && t < 300) begin @(posedge clk); #1; t++; end
      if (!in_ready) begin n_cmp++; n_err++; $display("FAIL send_ready in_ready=%0b required 1", in_ready); end
      in_valid = 1; in_data = 16'(x); in_ch = 8'(ch); in_d = 8'(d); in_h = 8'(h); in_w = 8'(w);
      @(posedge clk); #1;
      in_valid = 0;
   endtask

   task automatic wait_products(input int n);
      int t = 0;
      while (got.size() < n && t < 3000) begin @(posedge clk); #1; t++; end
      n_cmp++;
      if (got.size() != n) begin n_err++; $display("FAIL product_count got %0d required %0d", got.size(), n); end
      repeat (4) @(posedge clk);
      #1;
   endtask

   task automatic clear();
      got.delete(); exp_q.delete(); rd_cnt = 0; stall_rd = 0;
   endtask

   task automatic test_reset();
      rst_n = 0; in_valid = 0; out_ready = 1; in_data = 0; in_ch = 0; in_d = 0; in_h = 0; in_w = 0; w_data = 0;
      repeat (3) @(posedge clk);
      #1;
      n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL reset_in_ready got %b required 0", in_ready); end
      n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got %b required 0", out_valid); end
      n_cmp++; if ({w_rd_en, err_ch, out_last, out_keep} !== 4'b0) begin n_err++; $display("FAIL reset_flags got %b required 0000", {w_rd_en, err_ch, out_last, out_keep}); end
      n_cmp++; if (out_data !== 32'd0) begin n_err++; $display("FAIL reset_out_data got %h required 0", out_data); end
      rst_n = 1;
      #1;
      n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL release_in_ready got %b required 0", in_ready); end
      @(posedge clk); #1;
      n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL post_reset_in_ready got %b required 1", in_ready); end
   endtask

   task automatic test_origin_voxel();
      int c = 0, kc = 0;
      for (int i = 0; i < 4096; i++) mem[i] = 16'(i);
      clear();
      model(3, 0, 0, 0, 0);
      send(3, 0, 0, 0, 0);
      while (!out_valid && c < 10) begin @(posedge clk); #1; c++; end
      n_cmp++; if (c != 2) begin n_err++; $display("FAIL t1_latency got %0d required 2", c); end
      wait_products(NT);
      foreach (got[i]) kc += got[i].keep;
      n_cmp++; if (kc != 16) begin n_err++; $display("FAIL t1_keep_count got %0d required 16", kc); end
      n_cmp++; if (rd_cnt != 16) begin n_err++; $display("FAIL t1_reads got %0d required 16", rd_cnt); end
      if (got.size() > 13) begin
         n_cmp++;
         if (got[13].data !== 32'd39 || got[13].keep !== 1'b1 || got[13].ch !== 8'd0 || {got[13].d, got[13].h, got[13].w} !== 27'd0) begin
            n_err++; $display("FAIL t1_tap13 got %h required data 39 keep 1 ch 0 at origin", got[13]);
         end
      end
      for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
         n_cmp++; if (got[i] !== exp_q[i]) begin n_err++; $display("FAIL t1_prod[%0d] got %h required %h", i, got[i], exp_q[i]); end
      end
   endtask

   task automatic test_upper_group();
      int bad = 0;
      for (int i = 0; i < 4096; i++) mem[i] = 16'($urandom);
      clear();
      model(-2, 3, 3, 3, 3);
      send(-2, 3, 3, 3, 3);
      wait_products(NT);
      foreach (got[i]) if (got[i].ch != 8'd2 && got[i].ch != 8'd3) bad++;
      n_cmp++; if (bad != 0) begin n_err++; $display("FAIL t2_out_ch %0d products outside {2,3}", bad); end
      if (got.size() > 26) begin
         n_cmp++; if ({got[26].d, got[26].h, got[26].w, got[26].keep} !== {9'd7, 9'd7, 9'd7, 1'b1}) begin
            n_err++; $display("FAIL t2_tap222 got %h required (7,7,7) keep 1", got[26]);
         end
         n_cmp++; if ({got[0].d, got[0].h, got[0].w} !== {9'd5, 9'd5, 9'd5}) begin
            n_err++; $display("FAIL t2_tap000 got %h required (5,5,5)", got[0]);
         end
      end
      for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
         n_cmp++; if (got[i] !== exp_q[i]) begin n_err++; $display("FAIL t2_prod[%0d] got %h required %h", i, got[i], exp_q[i]); end
      end
   endtask

   task automatic test_stall();
      int x = int'($urandom_range(0, 65535)) - 32768;
      logic [68:0] snap;
      clear();
      model(x, 1, 1, 2, 3);
      send(x, 1, 1, 2, 3);
      repeat (10) @(posedge clk);
      #1;
      out_ready = 0;
      #1;
      snap = {out_data, out_keep, out_ch, out_d, out_h, out_w, out_last};
      for (int i = 0; i < 5; i++) begin
         n_cmp++; if (w_rd_en !== 1'b0 || out_valid !== 1'b1) begin n_err++; $display("FAIL t3_stall[%0d] w_rd_en=%b out_valid=%b required 0/1", i, w_rd_en, out_valid); end
         @(posedge clk); #1;
      end
      n_cmp++; if ({out_data, out_keep, out_ch, out_d, out_h, out_w, out_last} !== snap) begin
         n_err++; $display("FAIL t3_hold got %h required %h", {out_data, out_keep, out_ch, out_d, out_h, out_w, out_last}, snap);
      end
      out_ready = 1;
      wait_products(NT);
      n_cmp++; if (stall_rd != 0) begin n_err++; $display("FAIL t3_stall_reads got %0d required 0", stall_rd); end
      for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
         n_cmp++; if (got[i] !== exp_q[i]) begin n_err++; $display("FAIL t3_prod[%0d] got %h required %h", i, got[i], exp_q[i]); end
      end
   endtask

   task automatic test_back_to_back();
      int low = 0, lasts = 0;
      int xa = int'($urandom_range(0, 65535)) - 32768, xb = int'($urandom_range(0, 65535)) - 32768;
      clear();
      model(xa, 0, 2, 0, 3);
      model(xb, 2, 4, 1, 0);
      in_valid = 1; in_data = 16'(xa); in_ch = 8'd0; in_d = 8'd2; in_h = 8'd0; in_w = 8'd3;
      @(posedge clk); #1;
      in_data = 16'(xb); in_ch = 8'd2; in_d = 8'd4; in_h = 8'd1; in_w = 8'd0;
      while (!in_ready && low < 200) begin low++; @(posedge clk); #1; end
      n_cmp++; if (low != NT) begin n_err++; $display("FAIL t4_ready_low got %0d cycles required %0d", low, NT); end
      @(posedge clk); #1;
      in_valid = 0;
      wait_products(2 * NT);
      foreach (got[i]) lasts += got[i].last;
      n_cmp++; if (lasts != 2 || got.size() < 2 * NT || !got[NT-1].last || !got[2*NT-1].last) begin
         n_err++; $display("FAIL t4_last got %0d markers required 2 at #%0d and #%0d", lasts, NT, 2 * NT);
      end
      for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
         n_cmp++; if (got[i] !== exp_q[i]) begin n_err++; $display("FAIL t4_prod[%0d] got %h required %h", i, got[i], exp_q[i]); end
      end
   endtask

   task automatic test_bad_channel();
      clear();
      for (int ch = 4; ch <= 5; ch++) begin
         send(7, ch, 1, 1, 1);
         n_cmp++; if (err_ch !== 1'b1 || in_ready !== 1'b1) begin n_err++; $display("FAIL t5_err_pulse ch%0d err_ch=%b in_ready=%b required 1/1", ch, err_ch, in_ready); end
         @(posedge clk); #1;
         n_cmp++; if (err_ch !== 1'b0 || in_ready !== 1'b1) begin n_err++; $display("FAIL t5_err_end ch%0d err_ch=%b in_ready=%b required 0/1", ch, err_ch, in_ready); end
      end
      repeat (10) @(posedge clk);
      #1;
      n_cmp++; if (got.size() != 0) begin n_err++; $display("FAIL t5_no_output got %0d products required 0", got.size()); end
   endtask

   task automatic test_reset_mid_voxel();
      int x = int'($urandom_range(0, 65535)) - 32768;
      clear();
      send(x, 2, 3, 0, 2);
      repeat (20) @(posedge clk);
      #1;
      rst_n = 0;
      #1;
      n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b0 || w_rd_en !== 1'b0) begin
         n_err++; $display("FAIL t6_async out_valid=%b in_ready=%b w_rd_en=%b required 0/0/0", out_valid, in_ready, w_rd_en);
      end
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1;
      clear();
      @(posedge clk); #1;
      n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL t6_ready got %b required 1", in_ready); end
      repeat (8) @(posedge clk);
      #1;
      n_cmp++; if (got.size() != 0) begin n_err++; $display("FAIL t6_stale got %0d products required 0", got.size()); end
      model(x, 1, 0, 3, 4);
      send(x, 1, 0, 3, 4);
      wait_products(NT);
      for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
         n_cmp++; if (got[i] !== exp_q[i]) begin n_err++; $display("FAIL t6_prod[%0d] got %h required %h", i, got[i], exp_q[i]); end
      end
   endtask

   task automatic test_random_backpressure();
      for (int i = 0; i < 4096; i++) mem[i] = 16'($urandom);
      clear();
      done = 0;
      fork
         begin
            for (int v = 0; v < 5; v++) begin
               int x = int'($urandom_range(0, 65535)) - 32768;
               int ch = int'($urandom_range(0, 3)), d = int'($urandom_range(0, 4));
               int h = int'($urandom_range(0, 4)), w = int'($urandom_range(0, 4));
               model(x, ch, d, h, w);
               send(x, ch, d, h, w);
            end
            wait_products(5 * NT);
            done = 1;
         end
         begin
            while (!done) begin @(posedge clk); #1; out_ready = $urandom_range(0, 3) != 0; end
            out_ready = 1;
         end
      join
      n_cmp++; if (stall_rd != 0) begin n_err++; $display("FAIL rand_stall_reads got %0d required 0", stall_rd); end
      for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
         n_cmp++; if (got[i] !== exp_q[i]) begin n_err++; $display("FAIL rand_prod[%0d] got %h required %h", i, got[i], exp_q[i]); end
      end
   endtask

   initial begin
      test_reset();
      test_origin_voxel();
      test_upper_group();
      test_stall();
      test_back_to_back();
      test_bad_channel();
      test_reset_mid_voxel();
      test_random_backpressure();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
